// File: rtl/mips_lsu_bus_master.sv
// CPU-side MIPS load/store unit: one request at a time onto a word-aligned stalling bus,
// with load alignment/sign-extension, LWL/LWR merge, and a single-cycle response pulse.
module mips_lsu_bus_master #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned CW = 32;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDWAIT, S_RESP} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] w);
    case (op)
      OP_SB:   return {4{w[7:0]}};
      OP_SH:   return {2{w[15:0]}};
      OP_SW:   return w;
      default: return '0;
    endcase
  endfunction

  // Extract/extend the addressed lanes, or merge with old rt for unaligned word loads.
  function automatic logic [31:0] format_load(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] m, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = m[{a, 3'b000} +: 8];
    h = a[1] ? m[31:16] : m[15:0];
    case (op)
      OP_LB:  return {{24{b[7]}}, b};
      OP_LBU: return {24'b0, b};
      OP_LH:  return {{16{h[15]}}, h};
      OP_LHU: return {16'b0, h};
      OP_LW:  return m;
      OP_LWL: begin
        case (a)
          2'd0:    return {m[7:0], r[23:0]};
          2'd1:    return {m[15:0], r[15:0]};
          2'd2:    return {m[23:0], r[7:0]};
          default: return m;
        endcase
      end
      OP_LWR: begin
        case (a)
          2'd0:    return m;
          2'd1:    return {r[31:24], m[31:8]};
          2'd2:    return {r[31:16], m[31:16]};
          default: return {r[31:8], m[31:24]};
        endcase
      end
      default: return '0;
    endcase
  endfunction

  state_t        state, state_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    a_q, a_d;
  logic [31:0]   rt_q, rt_d;
  logic [31:0]   data_q, data_d;
  logic          ae_q, ae_d;
  logic          be_q, be_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          req_ready_d, resp_valid_d, addr_err_d, bus_err_d;
  logic [31:0]   resp_data_d, address_d, writedata_d;
  logic          write_d, read_d;
  logic [3:0]    byteenable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      rt_q       <= '0;
      data_q     <= '0;
      ae_q       <= 1'b0;
      be_q       <= 1'b0;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      address    <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      rt_q       <= rt_d;
      data_q     <= data_d;
      ae_q       <= ae_d;
      be_q       <= be_d;
      wait_cnt   <= wait_cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      addr_err   <= addr_err_d;
      bus_err    <= bus_err_d;
      address    <= address_d;
      write      <= write_d;
      read       <= read_d;
      byteenable <= byteenable_d;
      writedata  <= writedata_d;
    end
  end

  // Next-state and next-output logic; bus fields are cleared whenever the strobe drops.
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    a_d          = a_q;
    rt_d         = rt_q;
    data_d       = data_q;
    ae_d         = ae_q;
    be_d         = be_q;
    wait_cnt_d   = wait_cnt;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    address_d    = address;
    write_d      = write;
    read_d       = read;
    byteenable_d = byteenable;
    writedata_d  = writedata;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d       = req_op;
          a_d        = req_addr[1:0];
          rt_d       = req_rt;
          data_d     = '0;
          ae_d       = 1'b0;
          be_d       = 1'b0;
          wait_cnt_d = '0;
          if (!op_legal(req_op) || misaligned(req_op, req_addr[1:0])) begin
            ae_d    = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d      = S_REQ;
            write_d      = op_store(req_op);
            read_d       = !op_store(req_op);
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = lane_be(req_op, req_addr[1:0]);
            writedata_d  = lane_wdata(req_op, req_wdata);
          end
        end
      end
      S_REQ: begin
        if (!waitrequest || ((WAIT_LIMIT != 0) && (wait_cnt + CW'(1) == CW'(WAIT_LIMIT)))) begin
          be_d         = waitrequest;
          state_d      = (waitrequest || write) ? S_RESP : S_RDWAIT;
          write_d      = 1'b0;
          read_d       = 1'b0;
          address_d    = '0;
          byteenable_d = '0;
          writedata_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end
      end
      S_RDWAIT: begin
        data_d  = format_load(op_q, a_q, readdata, rt_q);
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        resp_data_d  = data_q;
        addr_err_d   = ae_q;
        bus_err_d    = be_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_mips_lsu_bus_master.sv
// Bench for mips_lsu_bus_master: directed table, reset corner cases, and random requests
// checked against an arithmetic reference model with a stalling slave.
module tb_mips_lsu_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        addr_err, bus_err;
  logic [31:0] address;
  logic        write, read;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_lsu_bus_master #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_data(resp_data), .addr_err(addr_err), .bus_err(bus_err),
    .address(address), .write(write), .read(read), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          nwait;
    logic [31:0] exp_data;
    bit          exp_ae;
    bit          exp_berr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_lat;
    int          exp_strobes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model computed from the op semantics with shifts and arithmetic.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] addr,
                                    input logic [31:0] w, input logic [31:0] r,
                                    input logic [31:0] m, output logic [31:0] data,
                                    output bit ae, output logic [3:0] be,
                                    output logic [31:0] wd);
    int unsigned a, size;
    logic [63:0] v, mask;
    bit legal;
    a     = 32'(addr[1:0]);
    legal = (op <= 4'd6) || (op >= 4'd8 && op <= 4'd10);
    size  = (op == 0 || op == 1 || op == 8) ? 1 : (op == 2 || op == 3 || op == 9) ? 2 : 4;
    ae    = !legal || (size == 2 && (a % 2) != 0) || ((op == 4 || op == 10) && a != 0);
    be    = (op == 5 || op == 6) ? 4'hF : 4'(((1 << size) - 1) << a);
    wd    = (op == 8) ? 32'(w[7:0]) * 32'h01010101 :
            (op == 9) ? 32'(w[15:0]) * 32'h00010001 : (op == 10) ? w : 32'h0;
    v     = 64'(m) >> (8 * a);
    data  = 32'h0;
    if (!ae) begin
      case (op)
        4'd0: begin v = v & 64'hFF;   data = 32'(v) - ((v >= 128) ? 32'd256 : 32'd0); end
        4'd1: data = 32'(v & 64'hFF);
        4'd2: begin v = v & 64'hFFFF; data = 32'(v) - ((v >= 32768) ? 32'd65536 : 32'd0); end
        4'd3: data = 32'(v & 64'hFFFF);
        4'd4: data = m;
        4'd5: begin
          mask = (64'h1 << (8 * (3 - a))) - 64'h1;
          data = 32'((64'(m) << (8 * (3 - a))) | (64'(r) & mask));
        end
        4'd6: begin
          mask = ~((64'h1 << (32 - 8 * a)) - 64'h1);
          data = 32'(v | (64'(r) & mask));
        end
        default: data = 32'h0;
      endcase
    end
  endfunction

  // Issue one request, act as a stalling slave, and check bus activity and the response.
  task automatic run_txn(input string tag, input vec_t t);
    int k, stalls, strobes;
    bit pend, seen, bus_ok, is_wr;
    logic [31:0] exp_addr;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check({tag, " ready timeout"}, 32'(req_ready), 32'd1);
    is_wr     = (t.op >= 4'd8);
    exp_addr  = {t.addr[31:2], 2'b00};
    req_valid = 1'b1;
    req_op    = t.op;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_rt    = t.rt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; stalls = 0; strobes = 0; pend = 1'b0; seen = 1'b0; bus_ok = 1'b1;
    while (1) begin
      readdata = pend ? t.rdata : $urandom;
      pend = 1'b0;
      if (resp_valid) begin
        seen = 1'b1;
        req_valid = 1'b0;
        break;
      end
      if (req_ready || (read && write)) bus_ok = 1'b0;
      if (read || write) begin
        strobes++;
        if (address !== exp_addr || byteenable !== t.exp_be || write !== is_wr ||
            read !== !is_wr || (is_wr && writedata !== t.exp_wd)) bus_ok = 1'b0;
        if (stalls < t.nwait) begin
          waitrequest = 1'b1;
          stalls++;
        end else begin
          waitrequest = 1'b0;
          pend = 1'b1;
        end
      end else begin
        waitrequest = 1'($urandom % 2);
      end
      req_valid = 1'($urandom % 2);
      req_op    = 4'($urandom);
      req_addr  = $urandom;
      if (k >= 100) break;
      @(posedge clk); #1;
      k++;
    end
    req_valid   = 1'b0;
    waitrequest = 1'b0;
    check({tag, " resp seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(t.exp_lat));
    check({tag, " resp_data"}, resp_data, t.exp_data);
    check({tag, " addr_err"}, 32'(addr_err), 32'(t.exp_ae));
    check({tag, " bus_err"}, 32'(bus_err), 32'(t.exp_berr));
    check({tag, " strobe cycles"}, 32'(strobes), 32'(t.exp_strobes));
    check({tag, " bus fields"}, 32'(bus_ok), 32'd1);
    @(posedge clk); #1;
    check({tag, " resp pulse"}, 32'(resp_valid), 32'd0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rt = '0;
    waitrequest = 1'b0; readdata = '0;

    //        op     addr       wdata         rt            rdata         nw   data          ae berr be     wd            lat str
    tbl[0]  = '{4'd10, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0,        0,   32'h0,        0, 0, 4'hF, 32'hDEADBEEF, 2,  1};
    tbl[1]  = '{4'd0,  32'h13, 32'h0,        32'h0,        32'hDEADBEEF, 0,   32'hFFFFFFDE, 0, 0, 4'h8, 32'h0,        3,  1};
    tbl[2]  = '{4'd1,  32'h13, 32'h0,        32'h0,        32'hDEADBEEF, 0,   32'h000000DE, 0, 0, 4'h8, 32'h0,        3,  1};
    tbl[3]  = '{4'd3,  32'h12, 32'h0,        32'h0,        32'hDEADBEEF, 0,   32'h0000DEAD, 0, 0, 4'hC, 32'h0,        3,  1};
    tbl[4]  = '{4'd5,  32'h11, 32'h0,        32'h11223344, 32'hDEADBEEF, 0,   32'hBEEF3344, 0, 0, 4'hF, 32'h0,        3,  1};
    tbl[5]  = '{4'd6,  32'h11, 32'h0,        32'h11223344, 32'hDEADBEEF, 0,   32'h11DEADBE, 0, 0, 4'hF, 32'h0,        3,  1};
    tbl[6]  = '{4'd9,  32'h16, 32'h00001234, 32'h0,        32'h0,        5,   32'h0,        0, 0, 4'hC, 32'h12341234, 7,  6};
    tbl[7]  = '{4'd4,  32'h06, 32'h0,        32'h0,        32'h0,        0,   32'h0,        1, 0, 4'hF, 32'h0,        1,  0};
    tbl[8]  = '{4'd7,  32'h00, 32'h0,        32'h0,        32'h0,        0,   32'h0,        1, 0, 4'hF, 32'h0,        1,  0};
    tbl[9]  = '{4'd4,  32'h20, 32'h0,        32'h0,        32'h12345678, 100, 32'h0,        0, 1, 4'hF, 32'h0,        17, 16};
    tbl[10] = '{4'd8,  32'h23, 32'h000000A5, 32'h0,        32'h0,        15,  32'h0,        0, 0, 4'h8, 32'hA5A5A5A5, 17, 16};

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset strobes", {30'd0, read, write}, 32'd0);
    check("reset resp", {29'd0, resp_valid, addr_err, bus_err}, 32'd0);
    check("reset address", address, 32'h0);
    check("reset byteenable", 32'(byteenable), 32'd0);
    check("reset resp_data", resp_data, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset asserted while a read is stalled in the bus phase.
    req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h40; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midreset read before", 32'(read), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset strobes", {30'd0, read, write}, 32'd0);
    check("midreset resp_valid", 32'(resp_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    waitrequest = 1'b0;
    @(posedge clk); #1;
    check("midreset req_ready", 32'(req_ready), 32'd1);
    run_txn("post reset", tbl[1]);

    for (int i = 0; i < 70; i++) begin
      logic [31:0] d;
      bit          ae;
      logic [3:0]  be;
      logic [31:0] wd;
      rv.op    = 4'($urandom % 16);
      rv.addr  = $urandom;
      if ($urandom % 2 == 1) rv.addr[1:0] = 2'b00;
      rv.wdata = $urandom;
      rv.rt    = $urandom;
      rv.rdata = $urandom;
      rv.nwait = ($urandom % 8 == 0) ? int'(14 + $urandom % 5) : int'($urandom % 4);
      ref_model(rv.op, rv.addr, rv.wdata, rv.rt, rv.rdata, d, ae, be, wd);
      rv.exp_ae   = ae;
      rv.exp_berr = !ae && rv.nwait >= 16;
      rv.exp_data = rv.exp_berr ? 32'h0 : d;
      rv.exp_be   = be;
      rv.exp_wd   = wd;
      if (ae) begin
        rv.exp_lat = 1; rv.exp_strobes = 0;
      end else if (rv.exp_berr) begin
        rv.exp_lat = 17; rv.exp_strobes = 16;
      end else begin
        rv.exp_lat     = (rv.op >= 4'd8) ? 2 + rv.nwait : 3 + rv.nwait;
        rv.exp_strobes = rv.nwait + 1;
      end
      run_txn($sformatf("rnd%0d op%0d a%h", i, rv.op, rv.addr), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
